seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16, meaning consecutive identical synchronized samples required before a digit is captured (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535, meaning clock cycles with no capture before the stale condition is declared.
REQ-003 SHALL have port clk  input  1  the single system clock; all flops on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports an3, an2, an1, an0  input  1 each  digit anodes, active-low, asynchronous to clk.
REQ-006 SHALL have ports ca, cb, cc, cd, ce, cf, cg  input  1 each  segment cathodes, active-low.
REQ-007 SHALL have port dp  input  1  decimal point cathode, active-low.
REQ-008 SHALL have ports val3, val2, val1, val0  output  4 each  last decoded hex value per digit.
REQ-009 SHALL have ports dot3, dot2, dot1, dot0  output  1 each  last captured dot per digit, 1 = lit.
REQ-010 SHALL have port digit_valid  output  4  bit n = digit n captured since reset or last stale.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when all four digits have been captured in the current frame.
REQ-012 SHALL have port seg_err  output  1  one-cycle pulse on a stable, single-anode, undecodable segment pattern.
REQ-013 SHALL have port stale  output  1  level; high while no capture has occurred for TIMEOUT_CYC cycles.

Function
REQ-014 SHALL pass all 12 inputs through a 2-flop synchronizer; the synchronized word S = {an3..an0, cg..ca, dp} is the only value used by downstream logic.
REQ-015 SHALL implement FSM states WAIT, SETTLE, HOLD.
REQ-016 WAIT: exactly one anode bit of S low -> SETTLE with stability counter = 1; otherwise stay in WAIT.
REQ-017 SETTLE: S differs from the previous cycle -> WAIT; zero or multiple anodes low -> WAIT; counter reaches SETTLE_CYC -> capture, then HOLD.
REQ-018 HOLD: remain while S is unchanged; any change in S -> WAIT; an identical pattern SHALL never be recaptured.
REQ-019 Capture SHALL decode segments with the standard active-low hex table (0=1000000 ... F=0001110, order cg..ca); on a hit, write val/dot of the low anode and set its digit_valid and frame mask bits.
REQ-020 Capture of an unmatched pattern (including all-off 1111111) SHALL pulse seg_err and leave val/dot/digit_valid/frame mask unchanged.
REQ-021 Latency: val/dot SHALL update on the clock edge SETTLE_CYC+3 cycles after a pin change that is then held stable.
REQ-022 When the frame mask becomes 4'b1111, frame_done SHALL pulse for one cycle and the frame mask SHALL clear on the same edge.
REQ-023 The timeout counter SHALL reset on every successful capture and saturate at TIMEOUT_CYC; on reaching it, stale = 1, digit_valid = 0, frame mask = 0, with val/dot retained.
REQ-024 stale SHALL clear on the edge of the next successful capture.
REQ-025 Simultaneous capture and timeout expiry: the capture SHALL win.
REQ-026 Recapturing an already-masked digit within a frame SHALL update val/dot and SHALL NOT pulse frame_done.

Reset
REQ-027 On rst high, the following SHALL clear asynchronously: FSM to WAIT, all counters, sync flops, frame mask, val* = 0, dot* = 0, digit_valid = 0, frame_done = 0, seg_err = 0, stale = 0.
REQ-028 rst asserted mid-SETTLE or mid-HOLD SHALL abort without a capture; the first capture after release SHALL require the full SETTLE_CYC.

Structure
REQ-029 A shared package seg_pkg SHALL hold the 16-entry segment table constants, the FSM state enum, and the ANODE_W = 4 and SEG_W = 7 constants.
REQ-030 Decoding SHALL be a combinational sub-module seg_pattern_decode (7-bit pattern in; 4-bit value and hit flag out); all other logic SHALL be in seg_scan_decoder.

Verification
REQ-031 The bench SHALL check: an=1110, segs=0100100, dp=0, held 30 cycles -> val0=2, dot0=1, digit_valid=0001 on cycle 19 after the change.
REQ-032 The bench SHALL check: scan digits 0..3 with values 4,7,A,F -> frame_done pulses once after the 4th capture; a 5th capture of digit 0 gives no pulse.
REQ-033 The bench SHALL check: an=1100 held 100 cycles -> no capture and no seg_err; an=1101, segs=1111111 stable -> seg_err pulses once, val1 unchanged.
REQ-034 The bench SHALL check: pattern toggled every 10 cycles (less than SETTLE_CYC) -> no capture ever.
REQ-035 The bench SHALL check: TIMEOUT_CYC=100, one capture, then silence -> stale=1 and digit_valid=0 at cycle 100 with val retained; the next capture clears stale.
REQ-036 The bench SHALL check: rst pulsed at SETTLE count 10 -> all outputs return to 0 immediately and no capture follows until 16 stable cycles after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: widths, the active-low
// hex segment table (bit order cg..ca) and the capture FSM state type.
package seg_pkg;

    localparam int unsigned ANODE_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned WORD_W  = ANODE_W + SEG_W + 1;

    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        WAIT,
        SETTLE,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational lookup of an active-low segment pattern against the hex table;
// o_hit is low for any pattern outside the 16 hex glyphs.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic [3:0]       o_val,
    output logic             o_hit
);

    always_comb begin
        o_val = '0;
        o_hit = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i_seg == SEG_TABLE[i]) begin
                o_val = 4'(i);
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex values from a multiplexed 4-digit seven-segment bus by
// waiting for a stable single-anode pattern and decoding its segments.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       an3,
    input  logic       an2,
    input  logic       an1,
    input  logic       an0,
    input  logic       ca,
    input  logic       cb,
    input  logic       cc,
    input  logic       cd,
    input  logic       ce,
    input  logic       cf,
    input  logic       cg,
    input  logic       dp,
    output logic [3:0] val3,
    output logic [3:0] val2,
    output logic [3:0] val1,
    output logic [3:0] val0,
    output logic       dot3,
    output logic       dot2,
    output logic       dot1,
    output logic       dot0,
    output logic [3:0] digit_valid,
    output logic       frame_done,
    output logic       seg_err,
    output logic       stale
);

    localparam int unsigned      TO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYC);
    localparam logic [7:0]       SETTLE_MAX = 8'(SETTLE_CYC);

    logic [WORD_W-1:0]  w_raw;
    logic [WORD_W-1:0]  r_sync1;
    logic [WORD_W-1:0]  r_sync2;
    logic [WORD_W-1:0]  r_prev;
    logic [ANODE_W-1:0] w_an;
    logic [SEG_W-1:0]   w_seg;
    logic               w_dp;
    logic               w_changed;
    logic               w_one_low;
    logic [1:0]         w_digit;

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [7:0]         r_cnt;
    logic               w_capture;
    logic               w_cnt_load;
    logic               w_cnt_inc;

    logic [3:0]         w_dec_val;
    logic               w_dec_hit;
    logic               w_cap_ok;
    logic               w_cap_bad;

    logic [ANODE_W-1:0][3:0] r_val;
    logic [ANODE_W-1:0]      r_dot;
    logic [ANODE_W-1:0]      r_dv;
    logic [ANODE_W-1:0]      r_mask;
    logic                    r_frame_done;
    logic                    r_seg_err;
    logic                    r_stale;
    logic [TO_W-1:0]         r_to_cnt;

    assign w_raw     = {an3, an2, an1, an0, cg, cf, ce, cd, cc, cb, ca, dp};
    assign w_an      = r_sync2[WORD_W-1 -: ANODE_W];
    assign w_seg     = r_sync2[SEG_W:1];
    assign w_dp      = r_sync2[0];
    assign w_changed = (r_sync2 != r_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_comb begin
        w_one_low = 1'b1;
        w_digit   = 2'd0;
        case (w_an)
            4'b1110: w_digit = 2'd0;
            4'b1101: w_digit = 2'd1;
            4'b1011: w_digit = 2'd2;
            4'b0111: w_digit = 2'd3;
            default: w_one_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT:    if (w_one_low) w_state_nxt = SETTLE;
            SETTLE:  begin
                if (w_changed || !w_one_low) begin
                    w_state_nxt = WAIT;
                end else if (r_cnt == SETTLE_MAX) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD:    if (w_changed) w_state_nxt = WAIT;
            default: w_state_nxt = WAIT;
        endcase
    end

    // WAIT's own sample counts as the first stable one, hence the load of 1.
    always_comb begin
        w_capture  = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_inc  = 1'b0;
        case (r_state)
            WAIT:    w_cnt_load = 1'b1;
            SETTLE:  begin
                if (!w_changed && w_one_low) begin
                    if (r_cnt == SETTLE_MAX) begin
                        w_capture = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_load) begin
            r_cnt <= 8'd1;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    seg_pattern_decode u_decode (
        .i_seg (w_seg),
        .o_val (w_dec_val),
        .o_hit (w_dec_hit)
    );

    assign w_cap_ok  = w_capture &  w_dec_hit;
    assign w_cap_bad = w_capture & ~w_dec_hit;

    // A good capture takes priority over timeout expiry on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val        <= '0;
            r_dot        <= '0;
            r_dv         <= '0;
            r_mask       <= '0;
            r_frame_done <= 1'b0;
            r_seg_err    <= 1'b0;
            r_stale      <= 1'b0;
            r_to_cnt     <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_seg_err    <= w_cap_bad;
            if (w_cap_ok) begin
                r_val[w_digit] <= w_dec_val;
                r_dot[w_digit] <= ~w_dp;
                r_dv[w_digit]  <= 1'b1;
                r_to_cnt       <= '0;
                r_stale        <= 1'b0;
                if ((r_mask | ~w_an) == 4'b1111) begin
                    r_mask       <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_mask <= r_mask | ~w_an;
                end
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
                if (r_to_cnt == TO_MAX - 1'b1) begin
                    r_stale <= 1'b1;
                    r_dv    <= '0;
                    r_mask  <= '0;
                end
            end
        end
    end

    assign val3        = r_val[3];
    assign val2        = r_val[2];
    assign val1        = r_val[1];
    assign val0        = r_val[0];
    assign dot3        = r_dot[3];
    assign dot2        = r_dot[2];
    assign dot1        = r_dot[1];
    assign dot0        = r_dot[0];
    assign digit_valid = r_dv;
    assign frame_done  = r_frame_done;
    assign seg_err     = r_seg_err;
    assign stale       = r_stale;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus random scan traffic,
// compared every cycle against a run-length based reference model.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE = 16;
    localparam int unsigned TO_LIM [2] = '{65535, 100};
    // Active-high segment masks (gfedcba) for hex glyphs 0..F.
    localparam logic [6:0] HEX_ON [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pin_an  = 4'hF;
    logic [6:0] pin_seg = 7'h7F;
    logic       pin_dp  = 1'b1;

    logic [1:0][3:0][3:0] o_val;
    logic [1:0][3:0]      o_dot;
    logic [1:0][3:0]      o_dv;
    logic [1:0]           o_fd;
    logic [1:0]           o_err;
    logic [1:0]           o_stale;

    int n_checks = 0;
    int n_errors = 0;
    int fd_pulses = 0;
    int err_pulses = 0;

    // Reference model state
    logic [11:0]     d1, d2, run_val;
    int              run_len;
    logic            pre_valid;
    logic [3:0][3:0] m_val;
    logic [3:0]      m_dot;
    logic            m_err;
    logic [3:0]      m_dv [2];
    logic [3:0]      m_mask [2];
    logic            m_fd [2];
    logic            m_stale [2];
    int unsigned     m_to [2];

    always #5 clk = ~clk;

    seg_scan_decoder dut (
        .clk(clk), .rst(rst),
        .an3(pin_an[3]), .an2(pin_an[2]), .an1(pin_an[1]), .an0(pin_an[0]),
        .ca(pin_seg[0]), .cb(pin_seg[1]), .cc(pin_seg[2]), .cd(pin_seg[3]),
        .ce(pin_seg[4]), .cf(pin_seg[5]), .cg(pin_seg[6]), .dp(pin_dp),
        .val3(o_val[0][3]), .val2(o_val[0][2]), .val1(o_val[0][1]), .val0(o_val[0][0]),
        .dot3(o_dot[0][3]), .dot2(o_dot[0][2]), .dot1(o_dot[0][1]), .dot0(o_dot[0][0]),
        .digit_valid(o_dv[0]), .frame_done(o_fd[0]), .seg_err(o_err[0]), .stale(o_stale[0])
    );

    seg_scan_decoder #(.TIMEOUT_CYC(100)) dut_to (
        .clk(clk), .rst(rst),
        .an3(pin_an[3]), .an2(pin_an[2]), .an1(pin_an[1]), .an0(pin_an[0]),
        .ca(pin_seg[0]), .cb(pin_seg[1]), .cc(pin_seg[2]), .cd(pin_seg[3]),
        .ce(pin_seg[4]), .cf(pin_seg[5]), .cg(pin_seg[6]), .dp(pin_dp),
        .val3(o_val[1][3]), .val2(o_val[1][2]), .val1(o_val[1][1]), .val0(o_val[1][0]),
        .dot3(o_dot[1][3]), .dot2(o_dot[1][2]), .dot1(o_dot[1][1]), .dot0(o_dot[1][0]),
        .digit_valid(o_dv[1]), .frame_done(o_fd[1]), .seg_err(o_err[1]), .stale(o_stale[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        return ~HEX_ON[v];
    endfunction

    function automatic logic single_low(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

    function automatic logic [31:0] dut_word(input int k);
        return {5'd0, o_val[k], o_dot[k], o_dv[k], o_fd[k], o_err[k], o_stale[k]};
    endfunction

    function automatic logic [31:0] model_word(input int k);
        return {5'd0, m_val, m_dot, m_dv[k], m_fd[k], m_err, m_stale[k]};
    endfunction

    task automatic model_reset();
        d1 = '0; d2 = '0; run_val = '0; run_len = 1; pre_valid = 1'b0;
        m_val = '0; m_dot = '0; m_err = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_dv[k] = '0; m_mask[k] = '0; m_fd[k] = 1'b0; m_stale[k] = 1'b0; m_to[k] = 0;
        end
    endtask

    // A pattern is captured once, when its synchronized run reaches SETTLE+1
    // samples (SETTLE+2 if the run displaced another single-anode pattern).
    task automatic model_step(input logic [11:0] w, input logic r);
        logic [11:0] s;
        logic        cap, hit;
        int          dig, v;
        if (r) begin
            model_reset();
            return;
        end
        s = d2; d2 = d1; d1 = w;
        if (s == run_val) begin
            run_len++;
        end else begin
            pre_valid = single_low(run_val[11:8]);
            run_val = s;
            run_len = 1;
        end
        cap = single_low(s[11:8]) && (run_len == (pre_valid ? SETTLE + 2 : SETTLE + 1));
        hit = 1'b0; v = 0; dig = 0;
        for (int i = 0; i < 16; i++) if (seg_of(i) == s[7:1]) begin hit = 1'b1; v = i; end
        for (int i = 0; i < 4; i++) if (!s[8+i]) dig = i;
        m_err = cap && !hit;
        if (cap && hit) begin
            m_val[dig] = 4'(v);
            m_dot[dig] = ~s[0];
        end
        for (int k = 0; k < 2; k++) begin
            m_fd[k] = 1'b0;
            if (cap && hit) begin
                m_dv[k][dig] = 1'b1;
                m_mask[k][dig] = 1'b1;
                m_stale[k] = 1'b0;
                m_to[k] = 0;
                if (m_mask[k] == 4'hF) begin
                    m_fd[k] = 1'b1;
                    m_mask[k] = '0;
                end
            end else if (m_to[k] < TO_LIM[k]) begin
                m_to[k]++;
                if (m_to[k] == TO_LIM[k]) begin
                    m_stale[k] = 1'b1;
                    m_dv[k] = '0;
                    m_mask[k] = '0;
                end
            end
        end
    endtask

    task automatic tick();
        logic [11:0] w;
        logic        r;
        w = {pin_an, pin_seg, pin_dp};
        r = rst;
        @(posedge clk);
        #1;
        model_step(w, r);
        fd_pulses += int'(o_fd[0]);
        err_pulses += int'(o_err[0]);
        for (int k = 0; k < 2; k++) check_eq(k == 0 ? "cyc_dflt" : "cyc_to", dut_word(k), model_word(k));
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] sg, input logic d, input int n);
        pin_an = an; pin_seg = sg; pin_dp = d;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        drive(4'hF, 7'h7F, 1'b1, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("rst_async_dflt", dut_word(0), 32'd0);
        check_eq("rst_async_to", dut_word(1), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] an_g;
        #2;
        do_reset();
        idle(3);

        // Single digit: capture lands exactly SETTLE+3 edges after the change
        pin_an = 4'b1110; pin_seg = 7'b0100100; pin_dp = 1'b0;
        repeat (SETTLE + 2) tick();
        check_eq("lat_early_val0", 32'(o_val[0][0]), 32'd0);
        tick();
        check_eq("lat_val0", 32'(o_val[0][0]), 32'd2);
        check_eq("lat_dot0", 32'(o_dot[0][0]), 32'd1);
        check_eq("lat_dv", 32'(o_dv[0]), 32'b0001);
        repeat (30 - SETTLE - 3) tick();
        idle(3);

        // Full frame, then a recapture of digit 0
        do_reset();
        fd_pulses = 0;
        drive(4'b1110, seg_of(4), 1'b1, 25); idle(5);
        drive(4'b1101, seg_of(7), 1'b1, 25); idle(5);
        drive(4'b1011, seg_of(10), 1'b1, 25); idle(5);
        check_eq("frame_not_yet", 32'(fd_pulses), 32'd0);
        drive(4'b0111, seg_of(15), 1'b1, 25); idle(5);
        check_eq("frame_fd_once", 32'(fd_pulses), 32'd1);
        check_eq("frame_vals", 32'(o_val[0]), 32'hFA74);
        fd_pulses = 0;
        drive(4'b1110, seg_of(5), 1'b1, 25); idle(5);
        check_eq("recap_no_fd", 32'(fd_pulses), 32'd0);
        check_eq("recap_val0", 32'(o_val[0][0]), 32'd5);

        // Multiple anodes low, then a blank single-anode pattern
        do_reset();
        err_pulses = 0;
        drive(4'b1100, seg_of(8), 1'b0, 100); idle(3);
        check_eq("multi_dv", 32'(o_dv[0]), 32'd0);
        check_eq("multi_err", 32'(err_pulses), 32'd0);
        drive(4'b1101, seg_of(3), 1'b1, 25); idle(3);
        err_pulses = 0;
        drive(4'b1101, 7'h7F, 1'b1, 40); idle(3);
        check_eq("blank_err_once", 32'(err_pulses), 32'd1);
        check_eq("blank_val1_kept", 32'(o_val[0][1]), 32'd3);

        // Fast toggling never settles
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) drive(4'b1110, seg_of(2), 1'b1, 10);
            else            drive(4'b1101, seg_of(5), 1'b1, 10);
        end
        idle(3);
        check_eq("toggle_dv", 32'(o_dv[0]), 32'd0);
        check_eq("toggle_vals", 32'(o_val[0]), 32'd0);

        // Timeout on the short-timeout instance
        do_reset();
        idle(2);
        pin_an = 4'b1011; pin_seg = seg_of(9); pin_dp = 1'b1;
        repeat (SETTLE + 3) tick();
        check_eq("to_cap_dv", 32'(o_dv[1]), 32'b0100);
        repeat (30 - SETTLE - 3) tick();
        idle(100 - (30 - SETTLE - 3) - 1);
        check_eq("to_pre_stale", 32'(o_stale[1]), 32'd0);
        tick();
        check_eq("to_stale", 32'(o_stale[1]), 32'd1);
        check_eq("to_dv_clr", 32'(o_dv[1]), 32'd0);
        check_eq("to_val_kept", 32'(o_val[1][2]), 32'd9);
        pin_an = 4'b1110; pin_seg = seg_of(1); pin_dp = 1'b1;
        repeat (SETTLE + 2) tick();
        check_eq("to_still_stale", 32'(o_stale[1]), 32'd1);
        tick();
        check_eq("to_stale_clr", 32'(o_stale[1]), 32'd0);
        check_eq("to_recap_dv", 32'(o_dv[1]), 32'b0001);
        repeat (10) tick();
        idle(3);

        // Reset in the middle of settling
        do_reset();
        drive(4'b1110, seg_of(2), 1'b0, 25); idle(3);
        pin_an = 4'b1011; pin_seg = seg_of(15); pin_dp = 1'b1;
        repeat (12) tick();
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("mid_rst_dflt", dut_word(0), 32'd0);
        check_eq("mid_rst_to", dut_word(1), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (SETTLE + 2) tick();
        check_eq("mid_rst_early_dv", 32'(o_dv[0]), 32'd0);
        tick();
        check_eq("mid_rst_cap", 32'(o_val[0][2]), 32'd15);
        check_eq("mid_rst_cap_dv", 32'(o_dv[0]), 32'b0100);
        idle(3);

        // Random scan traffic
        do_reset();
        for (int i = 0; i < 80; i++) begin
            int d;
            logic [6:0] sg;
            d = int'($urandom_range(0, 3));
            sg = ($urandom % 5 == 0) ? 7'($urandom) : seg_of(int'($urandom_range(0, 15)));
            drive(~(4'b0001 << d), sg, 1'($urandom), int'($urandom_range(2, 30)));
            if ($urandom % 4 != 0) begin
                do an_g = 4'($urandom); while (single_low(an_g));
                drive(an_g, 7'($urandom), 1'($urandom), int'($urandom_range(1, 6)));
            end
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
